button_hold_repeater: RTL and testbench

- Consumer side of the periodic 500 ms tick strobe produced by the refresh counter.
- Takes a raw push-button and the tick strobe, and produces debounced events:
  - press_pulse on press.
  - repeat_pulse at tick-paced auto-repeat intervals while the button is held.
  - release_pulse on release.
- Sits between board button pins / tick generator and the control FSMs that step digits or menus.

---
 rtl/button_hold_repeater_pkg.sv | 19 +
 rtl/button_hold_repeater_btn_debounce.sv | 62 ++++++
 rtl/button_hold_repeater.sv | 139 +++++++++++++
 tb/tb_button_hold_repeater.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_hold_repeater_pkg.sv
// Shared constants and types for the button hold/auto-repeat logic.
// Provides the FSM state encoding, the default debounce length derived
// from the board clock, and the tick period shared with the tick generator.
package button_hold_repeater_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int TICK_MS     = 500;

  // 20 ms at 50 MHz -> 1_000_000 cycles
  localparam int DB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/button_hold_repeater_btn_debounce.sv
// Button synchronizer plus debounce counter.
// A changed synchronized level must persist for DB_CYCLES consecutive clocks
// before it is accepted into held.
// Ports:
//   clk, rst  - clock, async active-high reset
//   btn_raw   - asynchronous raw button level
//   held      - debounced level (registered)
//   rise/fall - high in the cycle whose clock edge will accept a change of
//               held; they depend only on registers, so a consumer can
//               register its own event on the same edge that held toggles
module btn_debounce
  import button_hold_repeater_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic held,
  output logic rise,
  output logic fall
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync_meta;
  logic          btn_sync;
  logic [CW-1:0] db_cnt;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      btn_sync  <= sync_meta;
    end
  end

  // The change is accepted on the edge that would complete DB_CYCLES
  // consecutive differing samples.
  assign accept = (btn_sync != held) && (db_cnt == DB_LAST);
  assign rise   = accept & ~held;
  assign fall   = accept & held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      held   <= 1'b0;
    end else if (btn_sync == held) begin
      db_cnt <= '0;
    end else if (accept) begin
      held   <= ~held;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/button_hold_repeater.sv
// Debounced button with tick-paced auto-repeat.
// Emits press_pulse on a debounced press, repeat_pulse after HOLD_TICKS
// ticks and then every REPEAT_TICKS ticks while held, and release_pulse on a
// debounced release. All outputs are registered.
// Ports:
//   clk, rst       - clock, async active-high reset
//   btn_raw        - asynchronous raw button level, 1 = pressed
//   tick           - one-cycle strobe from the 500 ms tick generator
//   held           - debounced level
//   press_pulse    - one-cycle strobe on press
//   repeat_pulse   - one-cycle strobe per auto-repeat
//   release_pulse  - one-cycle strobe on release
//   repeat_count   - repeats issued in the current hold, saturating
module button_hold_repeater
  import button_hold_repeater_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEFAULT,
  parameter int HOLD_TICKS   = 2,
  parameter int REPEAT_TICKS = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             tick,
  output logic             held,
  output logic             press_pulse,
  output logic             repeat_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] repeat_count
);

  localparam int MAX_TICKS = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);

  state_t           state;
  state_t           next_state;
  logic [TW-1:0]    tick_cnt;
  logic [TW-1:0]    next_tick_cnt;
  logic [CNT_W-1:0] next_count;
  logic [CNT_W-1:0] count_inc;
  logic             next_press;
  logic             next_repeat;
  logic             next_release;
  logic             rise;
  logic             fall;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .held   (held),
    .rise   (rise),
    .fall   (fall)
  );

  // Saturate instead of wrapping so a long hold never reads as a short one
  assign count_inc = (repeat_count == '1) ? repeat_count : repeat_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      repeat_count  <= '0;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= next_state;
      tick_cnt      <= next_tick_cnt;
      repeat_count  <= next_count;
      press_pulse   <= next_press;
      repeat_pulse  <= next_repeat;
      release_pulse <= next_release;
    end
  end

  // Release is checked before tick so that a coincident tick is dropped.
  // The press edge does not look at tick, so counting starts next cycle.
  always_comb begin
    next_state    = state;
    next_tick_cnt = tick_cnt;
    next_count    = repeat_count;
    next_press    = 1'b0;
    next_repeat   = 1'b0;
    next_release  = 1'b0;

    unique case (state)
      IDLE: begin
        if (rise) begin
          next_press    = 1'b1;
          next_tick_cnt = '0;
          next_count    = '0;
          next_state    = HOLD;
        end
      end

      HOLD: begin
        if (fall) begin
          next_release = 1'b1;
          next_state   = IDLE;
        end else if (tick) begin
          if (tick_cnt == HOLD_LAST) begin
            next_repeat   = 1'b1;
            next_count    = count_inc;
            next_tick_cnt = '0;
            next_state    = REPEAT;
          end else begin
            next_tick_cnt = tick_cnt + TW'(1);
          end
        end
      end

      REPEAT: begin
        if (fall) begin
          next_release = 1'b1;
          next_state   = IDLE;
        end else if (tick) begin
          if (tick_cnt == REPEAT_LAST) begin
            next_repeat   = 1'b1;
            next_count    = count_inc;
            next_tick_cnt = '0;
          end else begin
            next_tick_cnt = tick_cnt + TW'(1);
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_hold_repeater.sv
// Self-checking bench for button_hold_repeater.
// The stimulus process drives btn_raw/tick once per clock and runs a
// behavioural model that predicts every output event (press/repeat/release)
// with its edge number, held level and repeat_count; predictions go into a
// queue. A monitor on the falling edge pops and compares whenever the DUT
// shows a pulse, and flags predicted events that never appeared.
module tb_button_hold_repeater;

  localparam int DB    = 4;
  localparam int HOLDT = 2;
  localparam int REPT  = 1;
  localparam int CW    = 2;
  localparam int MAXC  = (1 << CW) - 1;

  typedef struct {
    int            edge_no;
    logic [2:0]    kind;    // {press, repeat, release}
    logic          held;
    logic [CW-1:0] count;
  } ev_t;

  logic          clk;
  logic          rst;
  logic          btn_raw;
  logic          tick;
  logic          held;
  logic          press_pulse;
  logic          repeat_pulse;
  logic          release_pulse;
  logic [CW-1:0] repeat_count;

  ev_t  exp_q[$];
  logic dly_q[$];
  logic win[$];
  logic m_held;
  int   m_ticks;
  int   m_count;
  int   edge_no;
  int   n_cmp;
  int   n_fail;

  button_hold_repeater #(
    .DB_CYCLES   (DB),
    .HOLD_TICKS  (HOLDT),
    .REPEAT_TICKS(REPT),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .tick         (tick),
    .held         (held),
    .press_pulse  (press_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .repeat_count (repeat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    dly_q   = {1'b0, 1'b0};
    win.delete();
    m_held  = 1'b0;
    m_ticks = 0;
    m_count = 0;
  endtask

  task automatic push_event(input logic [2:0] kind);
    ev_t e;
    e.edge_no = edge_no;
    e.kind    = kind;
    e.held    = m_held;
    e.count   = CW'(m_count);
    exp_q.push_back(e);
  endtask

  // Reference model of one clock edge, using the raw values present before it.
  // The synchronized sample is the raw level from two edges earlier; a new
  // level is accepted once the last DB synchronized samples taken since the
  // previous change all disagree with held. Repeats fall on tick numbers
  // HOLDT, HOLDT+REPT, HOLDT+2*REPT ... counted from the press.
  task automatic model_edge(input logic raw, input logic tk);
    logic sync_v;
    logic accept;
    int   n;
    edge_no++;
    sync_v = dly_q.pop_front();
    dly_q.push_back(raw);
    win.push_back(sync_v);
    if (win.size() > DB) void'(win.pop_front());
    accept = (win.size() == DB);
    foreach (win[i]) if (win[i] == m_held) accept = 1'b0;
    if (accept) begin
      m_held = !m_held;
      win.delete();
      if (m_held) begin
        m_ticks = 0;
        m_count = 0;
        push_event(3'b100);
      end else begin
        push_event(3'b001);
      end
    end else if (m_held && tk) begin
      m_ticks++;
      if (m_ticks >= HOLDT && ((m_ticks - HOLDT) % REPT) == 0) begin
        n = (m_ticks - HOLDT) / REPT + 1;
        m_count = (n > MAXC) ? MAXC : n;
        push_event(3'b010);
      end
    end
  endtask

  task automatic apply_stimulus(input logic raw, input logic tk);
    btn_raw = raw;
    tick    = tk;
    @(posedge clk);
    model_edge(raw, tk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " held"}, int'(held), 0);
    check_output({tag, " press_pulse"}, int'(press_pulse), 0);
    check_output({tag, " repeat_pulse"}, int'(repeat_pulse), 0);
    check_output({tag, " release_pulse"}, int'(release_pulse), 0);
    check_output({tag, " repeat_count"}, int'(repeat_count), 0);
  endtask

  // Called at posedge+1; asserts reset between clock edges, after the
  // monitor has sampled the previous edge.
  task automatic do_reset(input string tag);
    #6;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    ev_t  e;
    logic pulse;
    if (!rst) begin
      pulse = press_pulse | repeat_pulse | release_pulse;
      if (pulse) begin
        n_cmp++;
        if (exp_q.size() == 0 || exp_q[0].edge_no > edge_no) begin
          n_fail++;
          $display("[TB] FAIL unexpected_event edge %0d: got pulses=%b count=%0d, expected no event",
                   edge_no, {press_pulse, repeat_pulse, release_pulse}, repeat_count);
        end else begin
          e = exp_q.pop_front();
          if (e.edge_no != edge_no ||
              e.kind != {press_pulse, repeat_pulse, release_pulse} ||
              e.held != held || e.count != repeat_count) begin
            n_fail++;
            $display("[TB] FAIL event edge %0d: got pulses=%b held=%b count=%0d, expected pulses=%b held=%b count=%0d at edge %0d",
                     edge_no, {press_pulse, repeat_pulse, release_pulse}, held, repeat_count,
                     e.kind, e.held, e.count, e.edge_no);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_no) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL missed_event edge %0d: got no pulse, expected pulses=%b count=%0d",
                 edge_no, e.kind, e.count);
      end
    end
  end

  initial begin
    logic cur;
    int   len;
    n_cmp   = 0;
    n_fail  = 0;
    edge_no = 0;
    rst     = 1'b1;
    btn_raw = 1'b0;
    tick    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    $display("[TB] clean press and hold with repeats up to saturation");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0);
    for (int i = 1; i <= 70; i++) apply_stimulus(1'b1, (i % 10) == 0);

    $display("[TB] release accepted together with a tick");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1);

    $display("[TB] bounce shorter than the debounce window");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0);

    $display("[TB] reset while repeating");
    for (int i = 1; i <= 30; i++) apply_stimulus(1'b1, (i % 5) == 0);
    do_reset("reset_mid_hold");
    for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0);

    $display("[TB] randomized hold/bounce/tick traffic");
    cur = 1'b0;
    for (int s = 0; s < 120; s++) begin
      cur = ~cur;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 60));
      for (int i = 0; i < len; i++) apply_stimulus(cur, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) do_reset("reset_random");
    end

    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0);
    #10;
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL leftover_event: got nothing, expected pulses=%b at edge %0d", e.kind, e.edge_no);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
